// File: rtl/roimager_readout_seq.sv
// Row readout sequencer for imager #1 (ADC side of the exposure FSM).
//
// Answers the exposure FSM's FSMIND1 request, walks every pixel row through
// select / settle, ADC conversion and row reset, then hands control back
// through the FSMIND0 / FSMIND0ACK handshake.
//
// Ports:
//   CLKMPRE     in   single clock, rising edge
//   RESET       in   synchronous active-high reset
//   FSMIND1     in   readout request from exposure FSM (level)
//   FSMIND1ACK  out  readout request accepted (level)
//   FSMIND0     out  readout finished (level)
//   FSMIND0ACK  in   exposure FSM accepted FSMIND0 (level)
//   ROW_ADDR    out  row being read
//   ROW_SEL     out  row select to the array
//   PIXRES_ROW  out  per-row pixel reset
//   ADC_START   out  one-cycle conversion start pulse
//   ADC_DONE    in   conversion complete (sampled level)
//   ADC_TO      out  sticky conversion-timeout flag
//   CntRow      out  rows completed in current/last frame
//   CntFrame    out  frames completed since reset
//   rd_stat     out  state code (F1..F6)
module roimager_readout_seq #(
    parameter int unsigned C_NUM_ROWS    = 160,
    parameter int unsigned C_ROW_SETTLE  = 4,
    parameter int unsigned C_ROW_RST     = 2,
    parameter int unsigned C_ADC_TIMEOUT = 64
) (
    input  logic        CLKMPRE,
    input  logic        RESET,
    input  logic        FSMIND1,
    output logic        FSMIND1ACK,
    output logic        FSMIND0,
    input  logic        FSMIND0ACK,
    output logic [7:0]  ROW_ADDR,
    output logic        ROW_SEL,
    output logic        PIXRES_ROW,
    output logic        ADC_START,
    input  logic        ADC_DONE,
    output logic        ADC_TO,
    output logic [31:0] CntRow,
    output logic [31:0] CntFrame,
    output logic [7:0]  rd_stat
);

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_ACK  = 6'b000010,
        S_SEL  = 6'b000100,
        S_CONV = 6'b001000,
        S_RST  = 6'b010000,
        S_DONE = 6'b100000
    } state_e;

    localparam logic [15:0] SettleLast = 16'(C_ROW_SETTLE - 1);
    localparam logic [15:0] RstLast    = 16'(C_ROW_RST - 1);
    localparam logic [15:0] Timeout    = 16'(C_ADC_TIMEOUT);
    localparam logic [7:0]  LastRow    = 8'(C_NUM_ROWS - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ack1_d, ind0_d, row_sel_d, pixres_d, adc_start_d, adc_to_d;
    logic [7:0]  row_addr_d, rd_stat_d;
    logic [31:0] cnt_row_d, cnt_frame_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        ack1_d      = FSMIND1ACK;
        ind0_d      = FSMIND0;
        row_addr_d  = ROW_ADDR;
        cnt_row_d   = CntRow;
        cnt_frame_d = CntFrame;
        adc_to_d    = ADC_TO;
        adc_start_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (FSMIND1) state_d = S_ACK;
            end
            S_ACK: begin
                ack1_d     = 1'b1;
                cnt_row_d  = '0;
                row_addr_d = '0;
                state_d    = S_SEL;
            end
            S_SEL: begin
                if (cnt_q == SettleLast) begin
                    state_d     = S_CONV;
                    adc_start_d = 1'b1;
                end
            end
            S_CONV: begin
                // First conversion cycle carries ADC_START; DONE counts from the second.
                if (cnt_q != 16'd0 && ADC_DONE) begin
                    state_d = S_RST;
                end else if (cnt_q == Timeout) begin
                    state_d  = S_RST;
                    adc_to_d = 1'b1;
                end
            end
            S_RST: begin
                if (cnt_q == RstLast) begin
                    cnt_row_d = CntRow + 32'd1;
                    if (ROW_ADDR == LastRow) begin
                        state_d = S_DONE;
                    end else begin
                        row_addr_d = ROW_ADDR + 8'd1;
                        state_d    = S_SEL;
                    end
                end
            end
            S_DONE: begin
                // Ack only counts once FSMIND0 is actually visible, so a stale
                // high ack cannot complete the handshake without FSMIND0 ever rising.
                if (FSMIND0 && FSMIND0ACK) begin
                    ind0_d      = 1'b0;
                    ack1_d      = 1'b0;
                    cnt_frame_d = CntFrame + 32'd1;
                    state_d     = S_IDLE;
                end else begin
                    ind0_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack1_d  = 1'b0;
                ind0_d  = 1'b0;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;

        row_sel_d = (state_d == S_SEL) || (state_d == S_CONV);
        pixres_d  = (state_d == S_RST);

        case (state_d)
            S_IDLE:  rd_stat_d = 8'hF1;
            S_ACK:   rd_stat_d = 8'hF2;
            S_SEL:   rd_stat_d = 8'hF3;
            S_CONV:  rd_stat_d = 8'hF4;
            S_RST:   rd_stat_d = 8'hF5;
            S_DONE:  rd_stat_d = 8'hF6;
            default: rd_stat_d = 8'hF1;
        endcase
    end

    always_ff @(posedge CLKMPRE) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            FSMIND1ACK <= 1'b0;
            FSMIND0    <= 1'b0;
            ROW_ADDR   <= '0;
            ROW_SEL    <= 1'b0;
            PIXRES_ROW <= 1'b0;
            ADC_START  <= 1'b0;
            ADC_TO     <= 1'b0;
            CntRow     <= '0;
            CntFrame   <= '0;
            rd_stat    <= 8'hF1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            FSMIND1ACK <= ack1_d;
            FSMIND0    <= ind0_d;
            ROW_ADDR   <= row_addr_d;
            ROW_SEL    <= row_sel_d;
            PIXRES_ROW <= pixres_d;
            ADC_START  <= adc_start_d;
            ADC_TO     <= adc_to_d;
            CntRow     <= cnt_row_d;
            CntFrame   <= cnt_frame_d;
            rd_stat    <= rd_stat_d;
        end
    end

endmodule

// File: tb/tb_roimager_readout_seq.sv
// Scoreboard bench for roimager_readout_seq (4 rows, settle 4, reset 2, timeout 8).
module tb_roimager_readout_seq;

    logic        CLKMPRE = 1'b0;
    logic        RESET = 1'b1;
    logic        FSMIND1 = 1'b0;
    logic        FSMIND1ACK;
    logic        FSMIND0;
    logic        FSMIND0ACK = 1'b0;
    logic [7:0]  ROW_ADDR;
    logic        ROW_SEL;
    logic        PIXRES_ROW;
    logic        ADC_START;
    logic        ADC_DONE = 1'b0;
    logic        ADC_TO;
    logic [31:0] CntRow;
    logic [31:0] CntFrame;
    logic [7:0]  rd_stat;

    roimager_readout_seq #(
        .C_NUM_ROWS   (4),
        .C_ROW_SETTLE (4),
        .C_ROW_RST    (2),
        .C_ADC_TIMEOUT(8)
    ) dut (
        .CLKMPRE   (CLKMPRE),
        .RESET     (RESET),
        .FSMIND1   (FSMIND1),
        .FSMIND1ACK(FSMIND1ACK),
        .FSMIND0   (FSMIND0),
        .FSMIND0ACK(FSMIND0ACK),
        .ROW_ADDR  (ROW_ADDR),
        .ROW_SEL   (ROW_SEL),
        .PIXRES_ROW(PIXRES_ROW),
        .ADC_START (ADC_START),
        .ADC_DONE  (ADC_DONE),
        .ADC_TO    (ADC_TO),
        .CntRow    (CntRow),
        .CntFrame  (CntFrame),
        .rd_stat   (rd_stat)
    );

    always #5 CLKMPRE = ~CLKMPRE;

    typedef struct {
        logic [7:0] row;
        int         gap;
        logic       to;
    } start_t;

    typedef struct {
        int   gap;
        logic to;
        int   frame;
    } done_t;

    start_t q_start[$];
    done_t  q_done[$];
    int     q_ack[$];

    int checks = 0;
    int failures = 0;

    int   adc_mode = 0;   // 0: DONE 3 cycles after START, 1: never answers
    int   glitch_req = 0;
    int   glitch_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sel_sig(input int s);
        case (s)
            0:       return FSMIND0;
            1:       return FSMIND1ACK;
            2:       return rd_stat == 8'hF3;
            3:       return ROW_ADDR == 8'd1;
            4:       return ROW_ADDR == 8'd2;
            default: return !FSMIND0;
        endcase
    endfunction

    task automatic wait_for(input int s, input int lim, input string name);
        int n = 0;
        while (!sel_sig(s) && n < lim) begin
            @(negedge CLKMPRE);
            n++;
        end
        checks++;
        if (!sel_sig(s)) begin
            failures++;
            $display("FAIL wait_%s: condition not reached within %0d cycles", name, lim);
        end
    endtask

    // Expected record set for one full frame of 4 rows.
    task automatic push_frame(input int row_gap, input int done_gap, input logic to_first,
                              input logic to_rest, input int frame_no);
        start_t s;
        done_t  d;
        for (int r = 0; r < 4; r++) begin
            s.row = 8'(r);
            s.gap = (r == 0) ? 4 : row_gap;
            s.to  = (r == 0) ? to_first : to_rest;
            q_start.push_back(s);
        end
        d.gap   = done_gap;
        d.to    = to_rest;
        d.frame = frame_no - 1;
        q_done.push_back(d);
        q_ack.push_back(frame_no);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ind1ack"},  32'(FSMIND1ACK), 32'd0);
        check({tag, "_ind0"},     32'(FSMIND0),    32'd0);
        check({tag, "_row_addr"}, 32'(ROW_ADDR),   32'd0);
        check({tag, "_row_sel"},  32'(ROW_SEL),    32'd0);
        check({tag, "_pixres"},   32'(PIXRES_ROW), 32'd0);
        check({tag, "_adc_start"},32'(ADC_START),  32'd0);
        check({tag, "_adc_to"},   32'(ADC_TO),     32'd0);
        check({tag, "_cnt_row"},  CntRow,          32'd0);
        check({tag, "_cnt_frame"},CntFrame,        32'd0);
        check({tag, "_rd_stat"},  32'(rd_stat),    32'hF1);
    endtask

    task automatic wait_ack1_release();
        wait_for(1, 20, "ind1ack");
        FSMIND1 = 1'b0;
    endtask

    task automatic handshake(input bit rearm);
        wait_for(0, 300, "ind0_rise");
        FSMIND0ACK = 1'b1;
        @(negedge CLKMPRE);
        if (rearm) FSMIND1 = 1'b1;
        wait_for(5, 20, "ind0_fall");
        FSMIND0ACK = 1'b0;
    endtask

    // ADC model
    initial begin
        int adc_cnt = 0;
        forever begin
            @(negedge CLKMPRE);
            ADC_DONE = 1'b0;
            if (adc_cnt != 0) begin
                adc_cnt--;
                if (adc_cnt == 0) ADC_DONE = 1'b1;
            end
            if (glitch_req != glitch_ack) begin
                glitch_ack = glitch_req;
                ADC_DONE   = 1'b1;
            end
            if (ADC_START && adc_mode == 0) adc_cnt = 3;
        end
    end

    // Monitor: pops expected records when the DUT presents an event.
    initial begin
        logic   p_start = 1'b0, p_ind0 = 1'b0, p_ack1 = 1'b0;
        int     cyc = 0, ref_cyc = 0;
        start_t s;
        done_t  d;
        int     f;
        forever begin
            @(negedge CLKMPRE);
            cyc++;
            if (!RESET) begin
                if (FSMIND1ACK && !p_ack1) ref_cyc = cyc;
                if (ADC_START) begin
                    check("adc_start_single", 32'(p_start), 32'd0);
                    if (q_start.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_adc_start: row %0d, none expected", ROW_ADDR);
                    end else begin
                        s = q_start.pop_front();
                        check("start_row_addr", 32'(ROW_ADDR), 32'(s.row));
                        check("start_gap", 32'(cyc - ref_cyc), 32'(s.gap));
                        check("start_adc_to", 32'(ADC_TO), 32'(s.to));
                        check("start_row_sel", 32'(ROW_SEL), 32'd1);
                    end
                    ref_cyc = cyc;
                end
                if (FSMIND0 && !p_ind0) begin
                    if (q_done.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ind0: got rise, none expected");
                    end else begin
                        d = q_done.pop_front();
                        check("done_gap", 32'(cyc - ref_cyc), 32'(d.gap));
                        check("done_cnt_row", CntRow, 32'd4);
                        check("done_cnt_frame", CntFrame, 32'(d.frame));
                        check("done_adc_to", 32'(ADC_TO), 32'(d.to));
                        check("done_ind1ack", 32'(FSMIND1ACK), 32'd1);
                        check("done_rd_stat", 32'(rd_stat), 32'hF6);
                    end
                end
                if (!FSMIND0 && p_ind0) begin
                    if (q_ack.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ind0_fall: got fall, none expected");
                    end else begin
                        f = q_ack.pop_front();
                        check("ack_ind1ack_drop", 32'(FSMIND1ACK), 32'd0);
                        check("ack_cnt_frame", CntFrame, 32'(f));
                        check("ack_cnt_row", CntRow, 32'd4);
                        check("ack_rd_stat", 32'(rd_stat), 32'hF1);
                    end
                end
            end
            p_start = ADC_START;
            p_ind0  = FSMIND0;
            p_ack1  = FSMIND1ACK;
        end
    end

    initial begin
        repeat (20000) @(posedge CLKMPRE);
        $display("FAIL watchdog: bench did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle
        repeat (3) @(negedge CLKMPRE);
        RESET = 1'b0;
        @(negedge CLKMPRE);
        check_reset("rst");
        repeat (100) @(negedge CLKMPRE);
        check("idle_rd_stat", 32'(rd_stat), 32'hF1);
        check("idle_cnt_frame", CntFrame, 32'd0);

        // Frame 1 nominal, frame 2 back-to-back
        push_frame(10, 7, 1'b0, 1'b0, 1);
        FSMIND1 = 1'b1;
        wait_ack1_release();
        push_frame(10, 7, 1'b0, 1'b0, 2);
        handshake(1'b1);
        wait_ack1_release();
        handshake(1'b0);

        // Frame 3: ADC never answers
        adc_mode = 1;
        push_frame(15, 12, 1'b0, 1'b1, 3);
        FSMIND1 = 1'b1;
        wait_ack1_release();
        handshake(1'b0);
        adc_mode = 0;

        // Frame 4: spurious inputs mid-frame
        push_frame(10, 7, 1'b1, 1'b1, 4);
        FSMIND1 = 1'b1;
        wait_for(2, 20, "sel_row0");
        glitch_req++;
        wait_for(3, 100, "row1");
        FSMIND0ACK = 1'b1;
        @(negedge CLKMPRE);
        FSMIND0ACK = 1'b0;
        wait_for(4, 100, "row2");
        FSMIND1 = 1'b0;
        handshake(1'b0);

        // Frame 5 aborted by reset at row 2
        push_frame(10, 7, 1'b1, 1'b1, 5);
        FSMIND1 = 1'b1;
        wait_for(4, 100, "abort_row2");
        RESET   = 1'b1;
        FSMIND1 = 1'b0;
        q_start.delete();
        q_done.delete();
        q_ack.delete();
        @(negedge CLKMPRE);
        check_reset("midrst");
        RESET = 1'b0;
        push_frame(10, 7, 1'b0, 1'b0, 1);
        @(negedge CLKMPRE);
        FSMIND1 = 1'b1;
        wait_ack1_release();
        handshake(1'b0);

        repeat (10) @(negedge CLKMPRE);
        check("q_start_empty", 32'(q_start.size()), 32'd0);
        check("q_done_empty", 32'(q_done.size()), 32'd0);
        check("q_ack_empty", 32'(q_ack.size()), 32'd0);
        check("final_cnt_frame", CntFrame, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/roimager_readout_seq.md
# roimager_readout_seq

Row readout sequencer for imager #1, the ADC-side counterpart of the exposure FSM. It answers the exposure FSM's FSMIND1 request and walks all pixel rows: select, settle, ADC conversion, row reset. It then returns control through the FSMIND0/FSMIND0ACK handshake. Per-frame row and frame counters and a status word are exported for host readback.

## Interface
Parameters:
- C_NUM_ROWS, 160, pixel rows read per frame (max 256)
- C_ROW_SETTLE, 4, cycles ROW_SEL is held before conversion starts (≥1)
- C_ROW_RST, 2, cycles PIXRES_ROW is held after conversion (≥1)
- C_ADC_TIMEOUT, 64, max cycles waiting for ADC_DONE after ADC_START (≥2)

Ports:
- CLKMPRE  in  1  single clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- FSMIND1  in  1  exposure FSM requests readout (level)
- FSMIND1ACK  out  1  readout request accepted (level)
- FSMIND0  out  1  readout finished, exposure may resume (level)
- FSMIND0ACK  in  1  exposure FSM accepted FSMIND0 (level)
- ROW_ADDR  out  8  row being read
- ROW_SEL  out  1  row select to array
- PIXRES_ROW  out  1  per-row pixel reset
- ADC_START  out  1  one-cycle conversion start pulse
- ADC_DONE  in  1  ADC conversion complete (sampled level)
- ADC_TO  out  1  sticky: at least one conversion timed out since reset
- CntRow  out  32  rows completed in current/last frame
- CntFrame  out  32  frames completed since reset
- rd_stat  out  8  state code

## Operation
- All outputs are registered. Reset values: FSMIND1ACK=0, FSMIND0=0, ROW_ADDR=0, ROW_SEL=0, PIXRES_ROW=0, ADC_START=0, ADC_TO=0, CntRow=0, CntFrame=0, rd_stat=8'hF1. State returns to S_IDLE.
- One-hot states and their rd_stat codes:
  - S_IDLE (F1): wait for FSMIND1=1, then go to S_ACK.
  - S_ACK (F2): FSMIND1ACK<=1, CntRow<=0, ROW_ADDR<=0, go to S_SEL.
  - S_SEL (F3): ROW_SEL=1 for C_ROW_SETTLE cycles, then go to S_CONV.
  - S_CONV (F4): ADC_START=1 in the first cycle only. ADC_DONE is sampled from the second cycle on. When ADC_DONE=1, or when C_ADC_TIMEOUT cycles elapse without it (sets ADC_TO), go to S_RST.
  - S_RST (F5): ROW_SEL=0, PIXRES_ROW=1 for C_ROW_RST cycles, CntRow+1 on exit. If ROW_ADDR=C_NUM_ROWS-1, go to S_DONE. Otherwise ROW_ADDR+1 and go to S_SEL.
  - S_DONE (F6): FSMIND0<=1. Wait for FSMIND0ACK=1, then FSMIND0<=0, FSMIND1ACK<=0, CntFrame+1, go to S_IDLE.
- Illegal state: go to S_IDLE and clear the handshake outputs.
- ADC_DONE seen during S_SEL or S_RST is ignored.
- FSMIND1 dropping mid-readout is ignored: the frame always completes.
- FSMIND0ACK is honoured only in S_DONE. A high FSMIND0ACK left over from the previous frame does not affect S_IDLE.
- RESET mid-frame aborts immediately on the next edge, with all outputs at their reset values. The partially read frame is not counted.
- CntFrame and CntRow wrap modulo 2^32. ROW_ADDR never exceeds C_NUM_ROWS-1.

## Timing
- FSMIND1 high at edge N: S_ACK at N+1, FSMIND1ACK visible after N+2, ROW_SEL rises after N+2.
- Per-row cycles = C_ROW_SETTLE + 1 + D + C_ROW_RST, where D is the cycles from ADC_START to ADC_DONE sampled high (1..C_ADC_TIMEOUT).
- ADC_DONE already high in the cycle after ADC_START gives D=1.
- Timeout case: D=C_ADC_TIMEOUT, ADC_TO rises on the transition to S_RST.
- FSMIND0 rises one cycle after the last row's S_RST ends.
- FSMIND0 and FSMIND1ACK fall together one cycle after FSMIND0ACK is sampled high.
- Frame latency: 1 cycle (S_ACK) + C_NUM_ROWS × per-row cycles, measured from S_ACK entry to S_DONE entry.
- ADC_START is never high for two consecutive cycles.

## Test plan
- Reset check: pulse RESET, hold FSMIND1=0 -> all outputs at reset values, rd_stat=F1, no ADC_START for 100 cycles.
- Nominal frame: C_NUM_ROWS=4, ADC_DONE returns 3 cycles after each ADC_START.
  - Response: exactly 4 ADC_START pulses with ROW_ADDR 0,1,2,3, each row 4+1+3+2=10 cycles, then FSMIND0=1.
  - Handshake: FSMIND0ACK=1 -> FSMIND0 and FSMIND1ACK drop together, CntFrame=1, CntRow=4.
- Timeout: ADC_DONE tied 0, C_ADC_TIMEOUT=8 -> each row takes 4+1+8+2=15 cycles, ADC_TO=1 after row 0 and stays 1, frame still completes.
- Back-to-back frames: FSMIND1 re-asserted the cycle after FSMIND0ACK -> second frame starts, CntFrame=2 after second ack, ROW_ADDR restarts at 0.
- Spurious inputs: FSMIND1 dropped at row 2, FSMIND0ACK pulsed during row 1, ADC_DONE pulsed during S_SEL -> no effect, all 4 rows read, FSMIND0 raised normally.
- Reset mid-frame: RESET at row 2 of frame 1 -> next cycle all outputs at reset values, CntFrame=0, new frame on FSMIND1 starts at ROW_ADDR=0.
